// File: rtl/hilo_muldiv_ctrl.sv
// Iterative multiply/divide sequencer owning all HI/LO writes: radix-2 shift-add
// multiply, restoring divide, and same-cycle MTHI/MTLO moves while idle.
module hilo_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mt_hi,
    input  logic             mt_lo,
    input  logic [WIDTH-1:0] mt_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             WE_HI,
    output logic             WE_LO,
    output logic [WIDTH-1:0] HI_in,
    output logic [WIDTH-1:0] LO_in
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_CALC  = 2'b01,
        S_WRITE = 2'b10
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [CW-1:0]        cnt_r;
    logic                 op_div_r;
    logic                 neg_quo_r;
    logic                 neg_rem_r;
    logic [WIDTH-1:0]     opnd_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]     hi_res_r;
    logic [WIDTH-1:0]     lo_res_r;
    logic                 dbz_r;

    logic                 sign_a_s;
    logic                 sign_b_s;
    logic [WIDTH-1:0]     mag_a_s;
    logic [WIDTH-1:0]     mag_b_s;
    logic                 b_zero_s;
    logic                 last_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH-1:0]   mul_next_s;
    logic [WIDTH:0]       rem_shift_s;
    logic [WIDTH:0]       div_diff_s;
    logic [2*WIDTH-1:0]   div_next_s;
    logic [2*WIDTH-1:0]   step_s;
    logic [2*WIDTH-1:0]   prod_fix_s;
    logic [WIDTH-1:0]     hi_fin_s;
    logic [WIDTH-1:0]     lo_fin_s;

    // Operand preparation and one radix-2 iteration of the active operation.
    always_comb begin
        sign_a_s = ~op[0] & a[WIDTH-1];
        sign_b_s = ~op[0] & b[WIDTH-1];
        mag_a_s  = sign_a_s ? (~a + ONE_W) : a;
        mag_b_s  = sign_b_s ? (~b + ONE_W) : b;
        b_zero_s = (b == {WIDTH{1'b0}});
        last_s   = (cnt_r == CNT_LAST);

        // Multiply keeps the multiplier in the low half and shifts it out as the product shifts in.
        mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};

        // Divide keeps {remainder, dividend/quotient}; remainder < divisor so W+1 bits suffice.
        rem_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        div_diff_s  = rem_shift_s - {1'b0, opnd_r};
        if (div_diff_s[WIDTH]) begin
            div_next_s = {rem_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end else begin
            div_next_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end

        step_s     = op_div_r ? div_next_s : mul_next_s;
        prod_fix_s = neg_quo_r ? (~step_s + ONE_2W) : step_s;

        if (op_div_r) begin
            lo_fin_s = neg_quo_r ? (~step_s[WIDTH-1:0] + ONE_W) : step_s[WIDTH-1:0];
            hi_fin_s = neg_rem_r ? (~step_s[2*WIDTH-1:WIDTH] + ONE_W) : step_s[2*WIDTH-1:WIDTH];
        end else begin
            lo_fin_s = prod_fix_s[WIDTH-1:0];
            hi_fin_s = prod_fix_s[2*WIDTH-1:WIDTH];
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = (op[1] && b_zero_s) ? S_WRITE : S_CALC;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CALC: begin
                if (last_s) begin
                    state_s = S_WRITE;
                end else begin
                    state_s = S_CALC;
                end
            end
            S_WRITE: state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: operand capture, iteration and sign-corrected result capture.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_r     <= '0;
            op_div_r  <= 1'b0;
            neg_quo_r <= 1'b0;
            neg_rem_r <= 1'b0;
            opnd_r    <= '0;
            acc_r     <= '0;
            hi_res_r  <= '0;
            lo_res_r  <= '0;
            dbz_r     <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        cnt_r     <= '0;
                        op_div_r  <= op[1];
                        neg_quo_r <= sign_a_s ^ sign_b_s;
                        neg_rem_r <= sign_a_s;
                        opnd_r    <= op[1] ? mag_b_s : mag_a_s;
                        acc_r     <= {{WIDTH{1'b0}}, (op[1] ? mag_a_s : mag_b_s)};
                        dbz_r     <= op[1] & b_zero_s;
                        hi_res_r  <= a;
                        lo_res_r  <= {WIDTH{1'b1}};
                    end
                end
                S_CALC: begin
                    acc_r <= step_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (last_s) begin
                        hi_res_r <= hi_fin_s;
                        lo_res_r <= lo_fin_s;
                    end
                end
                S_WRITE: begin
                    cnt_r <= '0;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    // HI/LO write port: result in WRITE, moves only while idle and out of reset.
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        div_by_zero = 1'b0;
        WE_HI       = 1'b0;
        WE_LO       = 1'b0;
        HI_in       = '0;
        LO_in       = '0;
        case (state_r)
            S_IDLE: begin
                WE_HI = mt_hi & clr_n;
                WE_LO = mt_lo & clr_n;
                if (mt_hi && clr_n) begin
                    HI_in = mt_data;
                end else begin
                    HI_in = '0;
                end
                if (mt_lo && clr_n) begin
                    LO_in = mt_data;
                end else begin
                    LO_in = '0;
                end
            end
            S_CALC: begin
                busy = 1'b1;
            end
            S_WRITE: begin
                busy        = 1'b1;
                done        = 1'b1;
                div_by_zero = dbz_r;
                WE_HI       = 1'b1;
                WE_LO       = 1'b1;
                HI_in       = hi_res_r;
                LO_in       = lo_res_r;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed self-checking bench for hilo_muldiv_ctrl with hand-computed results.
module tb_hilo_muldiv_ctrl;

    logic        clk;
    logic        clr_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mt_hi;
    logic        mt_lo;
    logic [31:0] mt_data;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic        WE_HI;
    logic        WE_LO;
    logic [31:0] HI_in;
    logic [31:0] LO_in;

    int n_checks = 0;
    int n_fail   = 0;

    hilo_muldiv_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .op(op), .a(a), .b(b),
        .mt_hi(mt_hi), .mt_lo(mt_lo), .mt_data(mt_data),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .WE_HI(WE_HI), .WE_LO(WE_LO), .HI_in(HI_in), .LO_in(LO_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1; op = o; a = av; b = bv;
        tick();
        start = 1'b0; a = 32'h0; b = 32'h0;
    endtask

    task automatic finish_op(input string tag, input int n0, input logic [31:0] eh,
                             input logic [31:0] el, input logic edbz, input int en);
        int n;
        n = n0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check_eq({tag, ".busy_cycles"}, 64'(n), 64'(en));
        check_eq({tag, ".done"}, 64'(done), 64'd1);
        check_eq({tag, ".we"}, 64'({WE_HI, WE_LO}), 64'd3);
        check_eq({tag, ".hi"}, 64'(HI_in), 64'(eh));
        check_eq({tag, ".lo"}, 64'(LO_in), 64'(el));
        check_eq({tag, ".dbz"}, 64'(div_by_zero), 64'(edbz));
        tick();
        check_eq({tag, ".after"}, 64'({busy, done, div_by_zero, WE_HI, WE_LO}), 64'd0);
    endtask

    initial begin
        int n;
        clr_n = 1'b0; start = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0;
        mt_hi = 1'b0; mt_lo = 1'b0; mt_data = 32'h0;
        #1;
        check_eq("reset.ctrl", 64'({busy, done, div_by_zero, WE_HI, WE_LO}), 64'd0);
        check_eq("reset.data", {HI_in, LO_in}, 64'd0);
        tick(); tick();
        clr_n = 1'b1;
        tick();

        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op("multu_max", 1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33);
        launch(2'b00, 32'hFFFF_FFFD, 32'd5);
        finish_op("mult_neg", 1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33);
        launch(2'b10, 32'hFFFF_FFF9, 32'd2);
        finish_op("div_neg", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
        launch(2'b11, 32'd7, 32'd2);
        finish_op("divu_small", 1, 32'd1, 32'd3, 1'b0, 33);
        launch(2'b10, 32'd7, 32'hFFFF_FFFE);
        finish_op("div_negb", 1, 32'd1, 32'hFFFF_FFFD, 1'b0, 33);
        launch(2'b11, 32'hFFFF_FFFF, 32'h10);
        finish_op("divu_big", 1, 32'hF, 32'h0FFF_FFFF, 1'b0, 33);
        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("div_ovf", 1, 32'h0, 32'h8000_0000, 1'b0, 33);
        launch(2'b10, 32'h0000_1234, 32'h0);
        finish_op("div_zero", 1, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1);
        launch(2'b11, 32'hFFFF_FFF0, 32'h0);
        finish_op("divu_zero", 1, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, 1);

        // start and mt_hi pulsed mid-CALC must both be ignored
        launch(2'b01, 32'h10, 32'h20);
        n = 1;
        repeat (5) begin tick(); n++; end
        start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd4;
        mt_hi = 1'b1; mt_data = 32'hDEAD_BEEF;
        #1;
        check_eq("busy_mt.we", 64'({WE_HI, WE_LO}), 64'd0);
        check_eq("busy_mt.hi", 64'(HI_in), 64'd0);
        tick(); n++;
        start = 1'b0; mt_hi = 1'b0; a = 32'h0; b = 32'h0;
        finish_op("busy_ignore", n, 32'h0, 32'h200, 1'b0, 33);

        mt_lo = 1'b1; mt_data = 32'hCAFE_F00D;
        #1;
        check_eq("mtlo.we", 64'({WE_HI, WE_LO}), 64'd1);
        check_eq("mtlo.lo", 64'(LO_in), 64'hCAFE_F00D);
        check_eq("mtlo.hi", 64'(HI_in), 64'd0);
        tick();
        mt_lo = 1'b0;
        #1;
        check_eq("mtlo.off", 64'({WE_HI, WE_LO, busy}), 64'd0);

        // start together with mt_hi: move happens now, operation still runs
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
        mt_hi = 1'b1; mt_data = 32'h11;
        #1;
        check_eq("mt_start.we", 64'({WE_HI, WE_LO}), 64'd2);
        check_eq("mt_start.hi", 64'(HI_in), 64'h11);
        tick();
        start = 1'b0; mt_hi = 1'b0; a = 32'h0; b = 32'h0;
        finish_op("mt_start", 1, 32'h0, 32'd12, 1'b0, 33);

        // reset mid-CALC
        launch(2'b01, 32'hFFFF_FFFF, 32'h1234_5678);
        repeat (9) tick();
        clr_n = 1'b0;
        #1;
        check_eq("midrst.ctrl", 64'({busy, done, div_by_zero, WE_HI, WE_LO}), 64'd0);
        check_eq("midrst.data", {HI_in, LO_in}, 64'd0);
        tick(); tick();
        check_eq("midrst.hold", 64'({busy, WE_HI, WE_LO}), 64'd0);
        clr_n = 1'b1;
        tick();
        check_eq("midrst.idle", 64'({busy, done, WE_HI, WE_LO}), 64'd0);
        launch(2'b01, 32'd6, 32'd7);
        finish_op("multu_post_rst", 1, 32'h0, 32'd42, 1'b0, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_ctrl.md
# hilo_muldiv_ctrl

Iterative multiply/divide sequencer that owns all writes to the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU requests and MTHI/MTLO moves from the execute stage. It runs a radix-2 shift-add multiply or a restoring divide over WIDTH cycles. When the result is ready, it drives the HI/LO write enables and data for exactly one cycle. While an operation is in flight it holds `busy` high so the pipeline stalls any HI/LO access.

## Interface

Parameters:
- WIDTH, 32, operand and HI/LO register width.

Ports:
- clk  in  1  clock. Everything updates on the rising edge.
- clr_n  in  1  reset. Asynchronous, active-low.
- start  in  1  request pulse. Sampled only in IDLE.
- op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  multiplicand or dividend.
- b  in  WIDTH  multiplier or divisor.
- mt_hi  in  1  MTHI request.
- mt_lo  in  1  MTLO request.
- mt_data  in  WIDTH  data for MTHI/MTLO.
- busy  out  1  an operation is in flight (CALC or WRITE).
- done  out  1  one-cycle pulse in the cycle the result is written.
- div_by_zero  out  1  pulses together with done when a DIV/DIVU had b==0.
- WE_HI  out  1  HI write enable.
- WE_LO  out  1  LO write enable.
- HI_in  out  WIDTH  data to be written into HI.
- LO_in  out  WIDTH  data to be written into LO.

## Operation

- States and transitions:
  - IDLE: start → CALC, except DIV/DIVU with b==0, which goes → WRITE.
  - CALC: stays WIDTH cycles, then → WRITE.
  - WRITE: lasts 1 cycle, then → IDLE.
- Accepting a request in IDLE:
  - Latch op.
  - For signed ops (MULT, DIV), convert a and b to magnitudes and latch the result signs.
  - Clear the iteration counter and the accumulator/remainder.
- Multiply: each CALC cycle conditionally adds the multiplicand and shifts right across a 2*WIDTH product. The product uses an unsigned magnitude product; the signed case applies sign correction as specified below.
- Divide: each CALC cycle performs a restoring subtract-shift, producing one quotient bit per cycle.
- Sign correction is applied on the transition into WRITE:
  - Product sign = sign(a) XOR sign(b).
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Result mapping:
  - Multiply: HI = product[2W-1:W], LO = product[W-1:0].
  - Divide: LO = quotient, HI = remainder.
- Divide by zero: the result is HI = a, LO = all ones, and div_by_zero = 1.
- DIV of 0x80000000 by 0xFFFFFFFF yields LO = 0x80000000, HI = 0. There is no trap.
- In WRITE:
  - WE_HI = WE_LO = 1 and done = 1.
  - HI_in/LO_in carry the final result.
- MTHI/MTLO: accepted only in IDLE.
  - The write happens in the same cycle, with no state change.
  - WE_HI = mt_hi, WE_LO = mt_lo, and HI_in/LO_in = mt_data for each asserted request.
- Requests ignored outside IDLE:
  - start while busy is ignored and not queued.
  - mt_hi/mt_lo while busy are ignored. The pipeline guarantees a stall in this case.
- start together with mt_* in IDLE: the MT write occurs that cycle and the operation starts. The later WRITE overwrites both HI and LO.
- Outside WRITE and outside IDLE MT writes, WE_HI = WE_LO = 0 and HI_in = LO_in = 0.

## Timing

- Reset (clr_n = 0, at any time including mid-CALC):
  - State goes to IDLE; counter, operands and accumulator are cleared.
  - busy, done, div_by_zero, WE_HI, WE_LO = 0.
  - HI_in, LO_in = 0.
  - No partial result is ever written.
- Normal operation, with start sampled at edge E0:
  - busy = 1 from after E0.
  - CALC spans edges E1..E_WIDTH.
  - WRITE is the cycle after E_WIDTH; HI/LO capture at E_(WIDTH+1).
  - busy falls after E_(WIDTH+1).
  - Total busy = WIDTH+1 cycles (33 for WIDTH = 32).
- Divide by zero: WRITE is the cycle directly after E0, so busy = 1 cycle.
- A new start is accepted in the cycle immediately after WRITE.
- MT writes: 0 cycles of latency. WE and data are combinational from IDLE and mt_*, and are captured at the next edge.
- done, WE_HI/WE_LO and div_by_zero are high for exactly one cycle per operation.

## Test plan

1. MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → WRITE 33 cycles after start with HI=0xFFFFFFFE, LO=0x00000001 and a single done pulse.
2. MULT a=0xFFFFFFFD (-3), b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
3. DIV a=0xFFFFFFF9 (-7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7, b=2 → LO=3, HI=1.
4. DIV a=0x00001234, b=0 → next cycle WE_HI=WE_LO=1, HI=0x00001234, LO=0xFFFFFFFF, div_by_zero=1; busy high for 1 cycle.
5. Pulse start and mt_hi mid-CALC → both ignored and the original result is unchanged. mt_lo with mt_data=0xCAFEF00D in IDLE → WE_LO=1, LO_in=0xCAFEF00D in the same cycle, WE_HI=0.
6. Assert clr_n=0 at CALC cycle 10 → all outputs 0 immediately, no WE pulse. After release, MULTU 6×7 gives LO=42, HI=0.
